fall_through_fifo: RTL

Parametrised successor to the single-entry fall-through register. It is a DEPTH-entry valid/ready buffer with a combinational bypass when empty, a working synchronous clear and an occupancy output. It sits on streaming paths between producer and consumer stages where zero-latency forwarding and multi-beat elasticity are both required.

---
 rtl/fall_through_fifo.sv | 101 ++++++++++
 1 files changed

// File: rtl/fall_through_fifo.sv
// DEPTH-entry valid/ready FIFO with optional zero-latency bypass when empty,
// synchronous clear and a registered occupancy count.
module fall_through_fifo #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned FALL_THROUGH = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           clr_i,
  input  logic                           testmode_i,
  input  logic                           valid_i,
  output logic                           ready_o,
  input  logic [DATA_WIDTH-1:0]          data_i,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [DATA_WIDTH-1:0]          data_o,
  output logic [$clog2(DEPTH+1)-1:0]     usage_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam bit FT = (FALL_THROUGH != 0);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      rptr;
  logic [PTR_W-1:0]      wptr;
  logic [CNT_W-1:0]      count;

  logic empty;
  logic blocked;
  logic push;
  logic pop;
  logic wr_en;
  logic rd_en;

  // Test mode has no function; keep the port consumed.
  logic unused_testmode;
  assign unused_testmode = testmode_i;

  // Pointers wrap explicitly so non-power-of-two depths stay in range.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshake and output selection; ready never looks at ready_i.
  always_comb begin
    empty   = (count == '0);
    blocked = clr_i | rst_i;
    ready_o = (count < DEPTH_C) && !blocked;
    valid_o = 1'b0;
    data_o  = mem[rptr];
    if (!blocked) begin
      if (!empty) begin
        valid_o = 1'b1;
      end else if (FT) begin
        valid_o = valid_i;
      end
    end
    if (empty && FT) begin
      data_o = data_i;
    end
    push  = valid_i && ready_o;
    pop   = valid_o && ready_i;
    // An empty-buffer pop can only be a bypassed beat, which is never stored.
    wr_en = push && !(empty && pop);
    rd_en = pop && !empty;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) begin
        wptr <= next_ptr(wptr);
      end
      if (rd_en) begin
        rptr <= next_ptr(rptr);
      end
      if (wr_en && !rd_en) begin
        count <= count + CNT_W'(1);
      end else if (rd_en && !wr_en) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Storage is not reset; only pointers and count are.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wptr] <= data_i;
    end
  end

  assign usage_o = count;

endmodule
